// File: rtl/alu_exec_stage.sv
// Execute-stage sequencer: decodes one instruction, drives the external ALU, writes back R[rd]/flags.
// Latency: accept at E0, ALU operands valid after E1, writeback + done pulse after E2 (1 instr / 3 cycles).
// Backpressure: instr_ready high only in IDLE; optional retired counter under ALU_EXEC_RETIRE_CNT_EN.
module alu_exec_stage #(
    parameter int              DW      = 8,
    parameter logic [DW-1:0]   REG_RST = '0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          instr_valid,
    output logic          instr_ready,
    input  logic [7:0]    instr,
    output logic [DW-1:0] alu_in1,
    output logic [DW-1:0] alu_in2,
    output logic [2:0]    alu_mode,
    input  logic [DW-1:0] alu_out,
    input  logic          alu_flag_zero,
    input  logic          alu_flag_carry,
    output logic          flag_z,
    output logic          flag_c,
    output logic          done,
    input  logic [1:0]    dbg_sel,
    output logic [DW-1:0] dbg_data,
    output logic [15:0]   retired_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

    typedef struct packed {
        logic [2:0] op;
        logic       imm_sel;
        logic [1:0] rd;
        logic [1:0] rs;
    } instr_t;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_CMP = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_OR  = 3'd4;
    localparam logic [2:0] OP_XOR = 3'd5;
    localparam logic [2:0] OP_LI  = 3'd6;

    state_t        state, state_nxt;
    instr_t        instr_q;
    logic [DW-1:0] regs [4];

    logic [DW-1:0] imm_ext;
    logic [DW-1:0] src_dat;
    logic          wr_en;
    logic [DW-1:0] wr_dat;
    logic          flag_upd;
    logic          z_nxt;
    logic          c_nxt;

    assign imm_ext     = {{(DW-2){instr_q.rs[1]}}, instr_q.rs};
    assign src_dat     = instr_q.imm_sel ? imm_ext : regs[instr_q.rs];
    assign dbg_data    = regs[dbg_sel];

    always_comb begin
        state_nxt   = state;
        instr_ready = 1'b0;
        case (state)
            IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) state_nxt = EXEC;
            end
            EXEC:    state_nxt = WB;
            WB:      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Writeback decode; evaluated against the ALU result seen during WB.
    always_comb begin
        wr_en    = 1'b0;
        wr_dat   = alu_out;
        flag_upd = 1'b0;
        z_nxt    = (alu_out == '0);
        c_nxt    = 1'b0;
        case (instr_q.op)
            OP_ADD, OP_SUB: begin
                wr_en    = 1'b1;
                flag_upd = 1'b1;
                c_nxt    = alu_flag_carry;
            end
            OP_CMP: begin
                flag_upd = 1'b1;
                z_nxt    = alu_flag_zero;
                c_nxt    = alu_flag_carry;
            end
            OP_AND, OP_OR, OP_XOR: begin
                wr_en    = 1'b1;
                flag_upd = 1'b1;
            end
            OP_LI: begin
                wr_en  = 1'b1;
                wr_dat = imm_ext;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            instr_q  <= '0;
            alu_in1  <= '0;
            alu_in2  <= '0;
            alu_mode <= '0;
            flag_z   <= 1'b0;
            flag_c   <= 1'b0;
            done     <= 1'b0;
            for (int i = 0; i < 4; i++) regs[i] <= REG_RST;
        end else begin
            state <= state_nxt;
            done  <= 1'b0;
            case (state)
                IDLE: if (instr_valid) instr_q <= instr;
                EXEC: begin
                    alu_in1  <= src_dat;
                    alu_in2  <= regs[instr_q.rd];
                    alu_mode <= instr_q.op;
                end
                WB: begin
                    done <= 1'b1;
                    if (wr_en) regs[instr_q.rd] <= wr_dat;
                    if (flag_upd) begin
                        flag_z <= z_nxt;
                        flag_c <= c_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef ALU_EXEC_RETIRE_CNT_EN
    // Counts on the retiring edge, so it already includes the instruction whose done is high.
    logic [15:0] cnt_q;
    always_ff @(posedge clk) begin
        if (reset)           cnt_q <= 16'h0000;
        else if (state == WB) cnt_q <= cnt_q + 16'h0001;
    end
    assign retired_cnt = cnt_q;
`else
    assign retired_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_alu_exec_stage.sv
// Randomized bench for alu_exec_stage with a behavioural ALU and an architectural register-file model.
`timescale 1ns/1ps
module tb_alu_exec_stage;

    logic       clk = 1'b0;
    logic       reset;
    logic       instr_valid;
    logic       instr_ready;
    logic [7:0] instr;
    logic [7:0] alu_in1, alu_in2;
    logic [2:0] alu_mode;
    logic [7:0] alu_out;
    logic       alu_flag_zero, alu_flag_carry;
    logic       flag_z, flag_c, done;
    logic [1:0] dbg_sel;
    logic [7:0] dbg_data;
    logic [15:0] retired_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] m_reg [4];
    logic       m_z, m_c;
    int         m_cnt;

    always #10 clk = ~clk;

    alu_exec_stage #(.DW(8), .REG_RST(8'h00)) dut (
        .clk(clk), .reset(reset),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
        .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_mode(alu_mode),
        .alu_out(alu_out), .alu_flag_zero(alu_flag_zero), .alu_flag_carry(alu_flag_carry),
        .flag_z(flag_z), .flag_c(flag_c), .done(done),
        .dbg_sel(dbg_sel), .dbg_data(dbg_data), .retired_cnt(retired_cnt)
    );

    // Environment ALU: in1+in2, in2-in1 with borrow as carry, bitwise ops.
    always_comb begin
        logic [8:0] s;
        s = 9'h0;
        alu_flag_carry = 1'b0;
        case (alu_mode)
            3'd0:    begin s = {1'b0, alu_in1} + {1'b0, alu_in2}; alu_flag_carry = s[8]; end
            3'd1, 3'd2: begin s = {1'b0, alu_in2 - alu_in1}; alu_flag_carry = (alu_in2 < alu_in1); end
            3'd3:    s = {1'b0, alu_in1 & alu_in2};
            3'd4:    s = {1'b0, alu_in1 | alu_in2};
            3'd5:    s = {1'b0, alu_in1 ^ alu_in2};
            default: s = 9'h0;
        endcase
        alu_out       = s[7:0];
        alu_flag_zero = (s[7:0] == 8'h00);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int exp_cnt();
`ifdef ALU_EXEC_RETIRE_CNT_EN
        return m_cnt & 16'hFFFF;
`else
        return 0;
`endif
    endfunction

    function automatic logic [7:0] sext2(input logic [1:0] v);
        return v[1] ? (8'hFC | {6'd0, v}) : {6'd0, v};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_reg[i] = 8'h00;
        m_z = 1'b0; m_c = 1'b0; m_cnt = 0;
    endtask

    task automatic model_exec(input logic [7:0] ins);
        logic [2:0] op; logic [1:0] rd; logic [7:0] src, a; int sum;
        op  = ins[7:5]; rd = ins[3:2];
        src = ins[4] ? sext2(ins[1:0]) : m_reg[ins[1:0]];
        a   = m_reg[rd];
        case (op)
            3'd0: begin sum = int'(a) + int'(src); m_reg[rd] = sum[7:0];
                        m_z = (sum[7:0] == 0); m_c = (sum > 255); end
            3'd1: begin m_reg[rd] = a - src; m_z = (a == src); m_c = (a < src); end
            3'd2: begin m_z = (a == src); m_c = (a < src); end
            3'd3: begin m_reg[rd] = a & src; m_z = ((a & src) == 0); m_c = 1'b0; end
            3'd4: begin m_reg[rd] = a | src; m_z = ((a | src) == 0); m_c = 1'b0; end
            3'd5: begin m_reg[rd] = a ^ src; m_z = ((a ^ src) == 0); m_c = 1'b0; end
            3'd6: m_reg[rd] = sext2(ins[1:0]);
            default: ;
        endcase
        m_cnt++;
    endtask

    task automatic check_state(input string tag);
        for (int i = 0; i < 4; i++) begin
            dbg_sel = 2'(i);
            #1;
            check({tag, "_r", $sformatf("%0d", i)}, dbg_data, m_reg[i]);
        end
        check({tag, "_z"}, flag_z, m_z);
        check({tag, "_c"}, flag_c, m_c);
        check({tag, "_cnt"}, retired_cnt, exp_cnt());
    endtask

    task automatic pulse_reset();
        @(negedge clk); reset = 1'b1; instr_valid = 1'b0;
        @(negedge clk); reset = 1'b0;
        model_reset();
    endtask

    // Issues one instruction and checks timing, ALU operands and the retired state.
    task automatic issue(input logic [7:0] ins, input string tag);
        int guard; logic [7:0] e_in1, e_in2;
        @(negedge clk);
        guard = 0;
        while (!instr_ready && guard < 8) begin @(negedge clk); guard++; end
        if (!instr_ready) check({tag, "_ready_timeout"}, 0, 1);
        e_in1 = ins[4] ? sext2(ins[1:0]) : m_reg[ins[1:0]];
        e_in2 = m_reg[ins[3:2]];
        instr = ins; instr_valid = 1'b1;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        instr = 8'($urandom);
        check({tag, "_busy"}, instr_ready, 0);
        @(posedge clk); #1;
        check({tag, "_done_early"}, done, 0);
        if (ins[7:5] <= 3'd5) begin
            check({tag, "_in1"}, alu_in1, e_in1);
            check({tag, "_in2"}, alu_in2, e_in2);
            check({tag, "_mode"}, alu_mode, ins[7:5]);
        end
        @(posedge clk); #1;
        check({tag, "_done"}, done, 1);
        model_exec(ins);
        check_state(tag);
        @(posedge clk); #1;
        check({tag, "_done_once"}, done, 0);
    endtask

    initial begin
        reset = 1'b1; instr_valid = 1'b0; instr = 8'h00; dbg_sel = 2'd0;
        model_reset();
        @(negedge clk); @(negedge clk); reset = 1'b0;
        check("rst_ready", instr_ready, 1);
        check("rst_done", done, 0);
        check_state("rst");

        issue(8'hC5, "li_r1_1");                 // LI R1,1
        issue(8'h17, "add_r1_ff");               // ADD R1 += imm 11
        check("plan_add_r1", m_reg[1], 8'h00);
        issue(8'hCA, "li_r2_m2");                // LI R2,-2
        issue(8'hCD, "li_r3_1");                 // LI R3,1
        issue(8'h2B, "sub_r2_r3");               // SUB R2 -= R3 -> FD
        dbg_sel = 2'd2; #1; check("plan_sub_r2", dbg_data, 8'hFD);
        issue(8'h4F, "cmp_r3_r3");               // CMP R3,R3
        issue(8'hAF, "xor_r3_r3");               // XOR R3 ^= R3
        dbg_sel = 2'd3; #1; check("plan_xor_r3", dbg_data, 8'h00);

        // Back-to-back NOPs with valid held high.
        pulse_reset();
        @(negedge clk);
        instr = 8'hE0; instr_valid = 1'b1;
        for (int k = 0; k < 12; k++) begin
            if (k > 0) @(negedge clk);
            if (k == 10) instr_valid = 1'b0;
            check($sformatf("nop_ready_%0d", k), instr_ready, (k % 3 == 0));
            if (k > 0) check($sformatf("nop_done_%0d", k), done, (k % 3 == 0));
        end
        @(negedge clk);
        check("nop_done_last", done, 1);
        for (int k = 0; k < 4; k++) model_exec(8'hE0);
        check_state("nop");

        for (int t = 0; t < 150; t++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            issue(8'($urandom), $sformatf("rnd%0d", t));
        end

        // Reset asserted during WB of ADD R0 += imm 01.
        pulse_reset();
        @(negedge clk);
        instr = 8'h11; instr_valid = 1'b1;
        @(posedge clk); #1; instr_valid = 1'b0;
        @(posedge clk); #1;
        check("rwb_in1", alu_in1, 8'h01);
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        check("rwb_done", done, 0);
        check("rwb_ready", instr_ready, 1);
        check("rwb_in1_rst", alu_in1, 8'h00);
        model_reset();
        check_state("rwb");
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
        check("rwb_done_after", done, 0);
        check("rwb_ready_after", instr_ready, 1);
        dbg_sel = 2'd0; #1; check("rwb_r0", dbg_data, 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
